// File: rtl/arb_req_queue.sv
// Three-channel request queue feeding a round-robin arbiter: one FIFO per channel,
// request generation from occupancy, and a single registered pop port driven by a one-hot grant.
module arb_req_queue #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2:0]           wr_vld,
    input  logic [3*DW-1:0]      wr_data,
    output logic [2:0]           wr_rdy,
    output logic [2:0]           req_vld,
    input  logic [2:0]           grant,
    output logic                 out_vld,
    output logic [DW-1:0]        out_data,
    output logic [1:0]           out_ch,
    output logic                 grant_err,
    output logic [3*(AW+1)-1:0]  count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem    [3][DEPTH];
    logic [AW-1:0] wr_ptr [3];
    logic [AW-1:0] rd_ptr [3];
    logic [AW:0]   cnt    [3];

    logic       grant_onehot;
    logic       grant_multi;
    logic [2:0] push;
    logic [2:0] pop;
    logic       pop_any;
    logic [1:0] pop_ch;

    always_comb begin
        grant_onehot = (grant == 3'b001) || (grant == 3'b010) || (grant == 3'b100);
        grant_multi  = !grant_onehot && (grant != 3'b000);
    end

    // Requests come only from registered occupancy so the arbiter sees no loop through grant.
    for (genvar i = 0; i < 3; i++) begin : g_ch
        assign wr_rdy[i]  = !rst && (cnt[i] != FULL);
        assign req_vld[i] = en && !rst && (cnt[i] != '0);
        assign push[i]    = wr_vld[i] && wr_rdy[i];
        assign pop[i]     = en && grant[i] && grant_onehot && (cnt[i] != '0);
        assign count[i*(AW+1) +: AW+1] = cnt[i];
    end

    always_comb begin
        pop_any = |pop;
        pop_ch  = 2'd0;
        if (pop[1]) pop_ch = 2'd1;
        if (pop[2]) pop_ch = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                cnt[i] <= cnt[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop[i]};
            end
        end
    end

    // NOTE: storage is deliberately not reset; pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= wr_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_ch    <= 2'd0;
            grant_err <= 1'b0;
        end else begin
            out_vld <= pop_any;
            if (pop_any) begin
                out_data <= mem[pop_ch][rd_ptr[pop_ch]];
                out_ch   <= pop_ch;
            end
            if (en && grant_multi) grant_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
// Self-checking bench for arb_req_queue: directed test-plan steps plus a randomized phase,
// all checked against a queue-based reference model.
module tb_arb_req_queue;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [2:0]        wr_vld;
    logic [3*DW-1:0]   wr_data;
    logic [2:0]        wr_rdy;
    logic [2:0]        req_vld;
    logic [2:0]        grant;
    logic              out_vld;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic              grant_err;
    logic [3*CW-1:0]   count;

    logic [2:0] drv_grant;
    logic       use_arb;
    logic [2:0] arb_grant;
    int         arb_idx;
    logic [1:0] rr_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] q [3][$];
    logic          m_vld, m_err;
    logic [DW-1:0] m_data;
    logic [1:0]    m_ch;
    logic [DW-1:0] seen_data [$];
    logic [1:0]    seen_ch [$];

    arb_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .req_vld(req_vld), .grant(grant),
        .out_vld(out_vld), .out_data(out_data), .out_ch(out_ch),
        .grant_err(grant_err), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural round-robin arbiter: first requester at or after rr_ptr wins.
    always_comb begin
        arb_grant = 3'b000;
        arb_idx   = 0;
        for (int k = 2; k >= 0; k--) begin
            if (req_vld[(int'(rr_ptr) + k) % 3]) begin
                arb_grant = 3'b001 << ((int'(rr_ptr) + k) % 3);
                arb_idx   = (int'(rr_ptr) + k) % 3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= 2'd0;
        else if (use_arb && arb_grant != 3'b000) rr_ptr <= 2'((arb_idx + 1) % 3);
    end

    assign grant = use_arb ? arb_grant : drv_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        logic [2:0]      e_rdy;
        logic [2:0]      e_req;
        logic [3*CW-1:0] e_cnt;
        logic [2:0]      psh;
        int              pc;
        #1;
        for (int i = 0; i < 3; i++) begin
            e_rdy[i] = !rst && (q[i].size() != DEPTH);
            e_req[i] = en && !rst && (q[i].size() != 0);
            e_cnt[i*CW +: CW] = CW'(q[i].size());
        end
        check("wr_rdy", 32'(wr_rdy), 32'(e_rdy));
        check("req_vld", 32'(req_vld), 32'(e_req));
        check("count", 32'(count), 32'(e_cnt));

        if (rst) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            m_vld = 1'b0; m_data = '0; m_ch = 2'd0; m_err = 1'b0;
        end else begin
            pc = -1;
            if (en && $countones(grant) == 1) begin
                for (int i = 0; i < 3; i++) if (grant[i] && q[i].size() != 0) pc = i;
            end
            if (en && $countones(grant) > 1) m_err = 1'b1;
            for (int i = 0; i < 3; i++) psh[i] = wr_vld[i] && (q[i].size() < DEPTH);
            m_vld = (pc >= 0);
            if (pc >= 0) begin
                m_data = q[pc].pop_front();
                m_ch   = 2'(pc);
            end
            for (int i = 0; i < 3; i++) if (psh[i]) q[i].push_back(wr_data[i*DW +: DW]);
        end

        @(posedge clk);
        #1;
        check("out_vld", 32'(out_vld), 32'(m_vld));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ch", 32'(out_ch), 32'(m_ch));
        check("grant_err", 32'(grant_err), 32'(m_err));
        if (out_vld === 1'b1) begin
            seen_data.push_back(out_data);
            seen_ch.push_back(out_ch);
        end
    endtask

    initial begin
        logic [2:0] mg;
        int         r;
        rst = 1'b1; en = 1'b0; wr_vld = 3'b000; wr_data = '0;
        drv_grant = 3'b000; use_arb = 1'b0;
        m_vld = 1'b0; m_data = '0; m_ch = 2'd0; m_err = 1'b0;
        @(posedge clk);
        #1;

        // Reset/idle with writes attempted
        wr_vld = 3'b111; wr_data = 24'hAABBCC;
        repeat (3) cycle();
        rst = 1'b0; wr_vld = 3'b000;
        cycle();
        check("wr_rdy_after_rst", 32'(wr_rdy), 32'h7);

        // Fill channel 0 past full
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_vld = 3'b001; wr_data = {16'h0, 8'(8'h10 + k)};
            cycle();
        end
        wr_vld = 3'b000;
        check("full_count0", 32'(count[CW-1:0]), 32'(DEPTH));

        // Drain channel 0 with a held grant, one extra grant past empty
        seen_data.delete(); seen_ch.delete();
        drv_grant = 3'b001;
        repeat (5) cycle();
        drv_grant = 3'b000;
        cycle();
        check("drain_pops", 32'(seen_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < seen_data.size(); k++) begin
            check("drain_data", 32'(seen_data[k]), 32'(8'h10 + k));
            check("drain_ch", 32'(seen_ch[k]), 32'd0);
        end

        // Simultaneous push/pop on channel 1 across pointer wrap
        seen_data.delete(); seen_ch.delete();
        drv_grant = 3'b010;
        for (int k = 0; k < 10; k++) begin
            wr_vld = 3'b010; wr_data = {8'h0, 8'(8'h20 + k), 8'h0};
            cycle();
        end
        wr_vld = 3'b000;
        check("wrap_pops", 32'(seen_data.size()), 32'd9);
        for (int k = 0; k < 9 && k < seen_data.size(); k++)
            check("wrap_data", 32'(seen_data[k]), 32'(8'h20 + k));
        cycle();
        drv_grant = 3'b000;
        cycle();

        // Round-robin integration: one word per channel
        wr_vld = 3'b111; wr_data = 24'h323130;
        cycle();
        wr_vld = 3'b000;
        seen_data.delete(); seen_ch.delete();
        use_arb = 1'b1;
        repeat (4) cycle();
        use_arb = 1'b0;
        check("rr_pops", 32'(seen_ch.size()), 32'd3);
        for (int k = 0; k < 3 && k < seen_ch.size(); k++) begin
            check("rr_ch", 32'(seen_ch[k]), 32'(k));
            check("rr_data", 32'(seen_data[k]), 32'(8'h30 + k));
        end
        check("rr_req_idle", 32'(req_vld), 32'd0);

        // Multi-hot grant, then enable off
        wr_vld = 3'b111; wr_data = 24'h504140;
        cycle();
        wr_vld = 3'b000; drv_grant = 3'b011;
        cycle();
        drv_grant = 3'b000;
        repeat (2) cycle();
        check("err_sticky", 32'(grant_err), 32'd1);
        en = 1'b0; drv_grant = 3'b100; wr_vld = 3'b100; wr_data = 24'h510000;
        repeat (2) cycle();
        wr_vld = 3'b000;
        cycle();
        check("en_off_count2", 32'(count[2*CW +: CW]), 32'd3);

        // Reset with a qualified pop pending
        en = 1'b1; rst = 1'b1;
        cycle();
        rst = 1'b0; drv_grant = 3'b000;
        cycle();
        check("err_cleared", 32'(grant_err), 32'd0);

        // Randomized phase
        for (int t = 0; t < 400; t++) begin
            rst     = ($urandom_range(0, 49) == 0);
            en      = ($urandom_range(0, 7) != 0);
            wr_vld  = 3'($urandom);
            wr_data = 24'($urandom);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                mg = 3'($urandom_range(3, 7));
                if (mg == 3'b100) mg = 3'b101;
                drv_grant = mg;
            end else if (r < 6) begin
                drv_grant = 3'b000;
            end else begin
                drv_grant = 3'b001 << $urandom_range(0, 2);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_req_queue.md
# arb_req_queue

Three-channel request queue that sits directly upstream of the round-robin arbiter. Each channel buffers write-side words in its own FIFO and raises `req_vld[i]` while that FIFO holds data. It consumes the arbiter's one-hot `grant` by popping the granted channel's head word onto a single registered output port tagged with the channel index.

## Interface
Parameters:
- `DW`, 8, data width of each queued word
- `DEPTH`, 4, entries per channel FIFO; must be a power of two and ≥ 2
- `AW`, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `en`  in  1  global enable; gates requests and pops
- `wr_vld`  in  3  per-channel write valid
- `wr_data`  in  3*DW  per-channel write data; channel i occupies bits [i*DW +: DW]
- `wr_rdy`  out  3  per-channel ready; a word is written when `wr_vld[i] & wr_rdy[i]`
- `req_vld`  out  3  request vector, connected to arbiter `req_vld`
- `grant`  in  3  arbiter grant vector, connected from arbiter `o_grant`
- `out_vld`  out  1  one-cycle pulse: popped word valid
- `out_data`  out  DW  popped word
- `out_ch`  out  2  channel index of popped word (0..2)
- `grant_err`  out  1  sticky flag: multi-hot grant seen
- `count`  out  3*(AW+1)  per-channel occupancy, 0..DEPTH

## Operation
- Per channel: circular FIFO with `wr_ptr` and `rd_ptr` (AW bits, wrap modulo DEPTH) and an occupancy counter `cnt` (AW+1 bits).
- `wr_rdy[i] = ~rst & (cnt[i] != DEPTH)`. Writes are accepted independently of `en`.
- `req_vld[i] = en & (cnt[i] != 0)`. This is combinational from registered state, with no path from `grant`.
- Pop condition for channel i: `en & grant[i] & (cnt[i] != 0) & grant is one-hot`.
- On pop, the next cycle shows:
  - `out_vld` = 1
  - `out_data` = head word
  - `out_ch` = i
  - `rd_ptr[i]` advanced
- With no pop, `out_vld` = 0. `out_data` and `out_ch` hold their last values.
- Grant to an empty channel: ignored silently, no pop, no error. This covers the arbiter's grant lagging the last pop.
- Grant of 0 (no bits set): idle.
- Multi-hot grant (2 or 3 bits set): no pop on any channel, and `grant_err` is set. It stays set until `rst`.
- Grant while `en` = 0: ignored, no pop, no error.
- Push and pop on the same channel in the same cycle: both take effect and `cnt` is unchanged. When the FIFO is full, only the pop occurs, because `wr_rdy` = 0. When it is empty, only the push occurs.
- Counter update: `cnt` += push, −= pop. Overflow and underflow cannot occur under these rules.

## Timing
- Reset (`rst` high at a clock edge) sets all pointers and counts to 0, `out_vld` 0, `out_data` 0, `out_ch` 0, `grant_err` 0.
- While `rst` is high: `wr_rdy` = 0 and `req_vld` = 0.
- Reset mid-operation discards all queued words. A pop qualified in the reset cycle does not produce `out_vld`.
- Write latency: a word written at edge N makes `req_vld[i]` high after edge N, i.e. visible in cycle N+1.
- Pop latency: a grant qualified in cycle N produces `out_vld`/`out_data` in cycle N+1. `count` and `req_vld` reflect the pop in cycle N+1.
- Throughput: one pop per cycle total across all channels; one push per cycle per channel.
- A continuously held grant drains one word per cycle. `req_vld[i]` falls in the cycle after the last word is popped.
- Ordering: strict FIFO per channel. No ordering guarantee across channels beyond grant order.

## Test plan
- Reset/idle: hold `rst` 3 cycles with `wr_vld` = 3'b111. Required: `wr_rdy` = 0, `req_vld` = 0, `count` = 0, `out_vld` = 0, nothing stored. After `rst` falls, `wr_rdy` = 3'b111.
- Fill/full: with DEPTH = 4, write 0x10..0x14 to channel 0 on consecutive cycles. Required:
  - `wr_rdy[0]` = 0 once `count[0]` = 4, so 0x14 is not accepted.
  - `req_vld` = 3'b001 from the cycle after the first write.
- Drain order: grant = 3'b001 for 5 cycles on the full channel 0. Required:
  - `out_vld` pulses 4 times with `out_data` 0x10, 0x11, 0x12, 0x13 and `out_ch` = 0.
  - The 5th grant is ignored, `grant_err` stays 0, and `req_vld[0]` = 0 afterwards.
- Wrap and simultaneous push/pop: run 10 cycles of a single write plus grant on channel 1 with data 0x20..0x29. Required: `count[1]` stays 1 and outputs appear in order 0x20..0x28 one cycle behind, exercising pointer wrap.
- Round-robin integration: connect the arbiter, load one word into each channel, hold `en` = 1. Required: three `out_vld` pulses with `out_ch` sequence matching the arbiter's grant order, then `req_vld` = 0.
- Error and enable: drive grant = 3'b011 with both channels non-empty. Required: no `out_vld`, and `grant_err` = 1 held until `rst`. Then set `en` = 0 with grant = 3'b100 and data queued. Required: `req_vld` = 0, no pop, writes still accepted.
